vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Parametrised VGA raster timing generator, the successor to the fixed 800x600 timing block. It produces hsync/vsync with configurable polarity, a video-enable flag, and active-area pixel coordinates. It also produces line-start and frame-start strobes, all registered and mutually aligned, and advances only on a pixel-clock enable. It sits between the board clock and the pixel/maze renderers and feeds the VGA DAC pins directly.

## Interface
Parameters:
- `H_ACTIVE`, 800: visible pixels per line
- `H_FP`, 56: horizontal front porch, in pixels
- `H_SYNC`, 120: hsync pulse width, in pixels
- `H_BP`, 64: horizontal back porch, in pixels
- `V_ACTIVE`, 600: visible lines per frame
- `V_FP`, 37: vertical front porch, in lines
- `V_SYNC`, 6: vsync pulse width, in lines
- `V_BP`, 23: vertical back porch, in lines
- `H_POL`, 1: hsync active level
- `V_POL`, 1: vsync active level
- `CW`, 11: width of counters and coordinates; requires H_TOTAL ≤ 2^CW and V_TOTAL ≤ 2^CW

Ports:
- `clk`  in  1  system clock
- `clr`  in  1  asynchronous, active-low reset
- `ce`  in  1  pixel enable; tie to 1 for pixel-rate clk
- `hsync`  out  1  horizontal sync, level set by H_POL
- `vsync`  out  1  vertical sync, level set by V_POL
- `vidon`  out  1  high inside the active area
- `PixelX`  out  CW  active-area column; 0 when vidon=0
- `PixelY`  out  CW  active-area row; 0 when vidon=0
- `line_start`  out  1  one-ce-step strobe at hc=0
- `frame_start`  out  1  one-ce-step strobe at hc=0, vc=0

## Operation
- Derived values: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL is defined likewise.
- Horizontal counter `hc`:
  - runs 0..H_TOTAL-1 and advances only when ce=1
  - wraps to 0 after H_TOTAL-1
- Vertical counter `vc`:
  - advances only on the ce step where hc wraps
  - wraps to 0 after V_TOTAL-1
  - both counters wrap on the same step at (H_TOTAL-1, V_TOTAL-1)
- Line layout: active region [0, H_ACTIVE), then front porch, then sync [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), then back porch. The vertical layout is identical, counted in lines.
- Decode, per ce step, from the current (hc, vc):
  - vidon = (hc<H_ACTIVE) && (vc<V_ACTIVE)
  - PixelX = hc and PixelY = vc when vidon, else 0
  - hsync = H_POL inside the horizontal sync window, else !H_POL; vsync is likewise with V_POL
  - line_start = (hc==0); frame_start = (hc==0 && vc==0)
- Coordinate arithmetic needs no subtraction and never exceeds CW bits.
- With ce=0, counters and all outputs hold their values; strobes therefore stay high for the whole ce-low stretch.

## Timing
- Reset (clr=0, asynchronous, effective immediately):
  - hc=0, vc=0
  - hsync=!H_POL, vsync=!V_POL
  - vidon=0, PixelX=0, PixelY=0
  - line_start=0, frame_start=0
- After release, reset is synchronous to clk.
- Latency: all outputs are registered. On a clk edge with ce=1, outputs load the decode of the pre-advance (hc, vc) and the counters advance. Outputs therefore lag the counters by 1 ce step.
- First ce step after reset: outputs show (0,0), i.e. vidon=1, PixelX=0, PixelY=0, line_start=1, frame_start=1.
- All outputs share the same latency, so sync and coordinates never skew relative to each other.
- Reset asserted mid-frame: outputs go inactive at once. The next frame restarts at (0,0) with no partial line.
- Default period: 1040 × 666 = 692,640 ce steps per frame.

## Configuration
- `VGA_TIMING_PREFETCH_EN` defined:
  - adds outputs `NextX` (CW), `NextY` (CW) and `next_vidon` (1), all registered
  - these outputs reset to 0
  - the main outputs gain one extra ce-step register stage and become a delayed copy of the Next* stage plus their sync and strobe values
  - result: Next* leads PixelX/PixelY/vidon by exactly 1 ce step, so a 1-cycle ROM can be addressed from Next*
  - first valid main output appears on the 2nd ce step after reset
- Macro undefined: Next* ports do not exist and main-output latency is 1 ce step.

## Test plan
- Reset: hold clr=0 and toggle clk → hsync=0, vsync=0, vidon=0, PixelX/PixelY=0, strobes=0. Release, ce=1 → first step shows vidon=1, (0,0), frame_start=1.
- Line scan, defaults, ce=1:
  - vidon falls after PixelX=799
  - hsync is high for exactly 120 steps starting at step 856 of the line
  - line_start recurs every 1040 steps
- Frame wrap:
  - vsync is high for 6 lines starting at line 637
  - frame_start recurs every 692,640 steps
  - PixelY runs 0..599 then reads 0 outside the active area
- ce gating, ce=1 on every 3rd clk → identical output sequence, with each value held for 3 clks and no skipped coordinates.
- Polarity/size: H_POL=0, V_POL=0, 640x480 (H_FP=16, H_SYNC=96, H_BP=48; V_FP=10, V_SYNC=2, V_BP=33) → hsync low for 96 steps from step 656; H_TOTAL=800, V_TOTAL=525.
- Async reset mid-frame at (400,300), plus the prefetch build: outputs go inactive on the clr edge without waiting for clk. In the prefetch build, NextX equals PixelX+1 on every step within the active line.

Source files
------------

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA raster timing generator
//
// Purpose: free-running horizontal/vertical raster counters that advance on
// a pixel-clock enable, plus a registered decode of sync pulses, video
// enable, active-area coordinates and line/frame start strobes. All outputs
// share one register stage, so sync and coordinates never skew.
//
// Ports:
//   clk          system clock
//   clr          asynchronous active-low reset
//   ce           pixel enable; everything holds while low
//   hsync/vsync  sync pulses, active level H_POL / V_POL
//   vidon        high inside the active area
//   PixelX/Y     active-area coordinates, 0 outside the active area
//   line_start   high for the step showing hc=0
//   frame_start  high for the step showing hc=0, vc=0
//
// Optional feature macro: VGA_TIMING_PREFETCH_EN
//   Adds NextX/NextY/next_vidon, which lead PixelX/PixelY/vidon by one ce
//   step so a 1-cycle ROM can be addressed from them. The main outputs then
//   sit one ce step further behind the counters.

module vga_timing_gen #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 56,
  parameter int H_SYNC   = 120,
  parameter int H_BP     = 64,
  parameter int V_ACTIVE = 600,
  parameter int V_FP     = 37,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 23,
  parameter int H_POL    = 1,
  parameter int V_POL    = 1,
  parameter int CW       = 11
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          ce,
  output logic          hsync,
  output logic          vsync,
  output logic          vidon,
  output logic [CW-1:0] PixelX,
  output logic [CW-1:0] PixelY,
  output logic          line_start,
  output logic          frame_start
`ifdef VGA_TIMING_PREFETCH_EN
  ,
  output logic [CW-1:0] NextX,
  output logic [CW-1:0] NextY,
  output logic          next_vidon
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);

  // Window bounds are one bit wider than the counters because a bound may
  // equal 2^CW when a total exactly fills the counter range.
  localparam logic [CW:0] H_ACT   = (CW+1)'(H_ACTIVE);
  localparam logic [CW:0] HS_BEG  = (CW+1)'(H_ACTIVE + H_FP);
  localparam logic [CW:0] HS_END  = (CW+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW:0] V_ACT   = (CW+1)'(V_ACTIVE);
  localparam logic [CW:0] VS_BEG  = (CW+1)'(V_ACTIVE + V_FP);
  localparam logic [CW:0] VS_END  = (CW+1)'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic HS_ON = (H_POL != 0);
  localparam logic VS_ON = (V_POL != 0);

  logic [CW-1:0] hc, vc;

  // Raster counters
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      hc <= '0;
      vc <= '0;
    end else if (ce) begin
      if (hc == H_LAST) begin
        hc <= '0;
        vc <= (vc == V_LAST) ? '0 : vc + 1'b1;
      end else begin
        hc <= hc + 1'b1;
      end
    end
  end

  // Decode of the current (pre-advance) counter position
  logic [CW:0]   hc_w, vc_w;
  logic          d_vidon, d_hs, d_vs, d_ls, d_fs;
  logic [CW-1:0] d_x, d_y;

  always_comb begin
    hc_w    = {1'b0, hc};
    vc_w    = {1'b0, vc};
    d_vidon = (hc_w < H_ACT) && (vc_w < V_ACT);
    d_x     = d_vidon ? hc : '0;
    d_y     = d_vidon ? vc : '0;
    d_hs    = ((hc_w >= HS_BEG) && (hc_w < HS_END)) ? HS_ON : ~HS_ON;
    d_vs    = ((vc_w >= VS_BEG) && (vc_w < VS_END)) ? VS_ON : ~VS_ON;
    d_ls    = (hc == '0);
    d_fs    = (hc == '0) && (vc == '0);
  end

  // First output stage
  logic          s1_vidon, s1_hs, s1_vs, s1_ls, s1_fs;
  logic [CW-1:0] s1_x, s1_y;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      s1_vidon <= 1'b0;
      s1_x     <= '0;
      s1_y     <= '0;
      s1_hs    <= ~HS_ON;
      s1_vs    <= ~VS_ON;
      s1_ls    <= 1'b0;
      s1_fs    <= 1'b0;
    end else if (ce) begin
      s1_vidon <= d_vidon;
      s1_x     <= d_x;
      s1_y     <= d_y;
      s1_hs    <= d_hs;
      s1_vs    <= d_vs;
      s1_ls    <= d_ls;
      s1_fs    <= d_fs;
    end
  end

`ifdef VGA_TIMING_PREFETCH_EN
  assign NextX      = s1_x;
  assign NextY      = s1_y;
  assign next_vidon = s1_vidon;

  // Main outputs trail the prefetch stage by one ce step
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      vidon       <= 1'b0;
      PixelX      <= '0;
      PixelY      <= '0;
      hsync       <= ~HS_ON;
      vsync       <= ~VS_ON;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (ce) begin
      vidon       <= s1_vidon;
      PixelX      <= s1_x;
      PixelY      <= s1_y;
      hsync       <= s1_hs;
      vsync       <= s1_vs;
      line_start  <= s1_ls;
      frame_start <= s1_fs;
    end
  end
`else
  assign vidon       = s1_vidon;
  assign PixelX      = s1_x;
  assign PixelY      = s1_y;
  assign hsync       = s1_hs;
  assign vsync       = s1_vs;
  assign line_start  = s1_ls;
  assign frame_start = s1_fs;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - self-checking bench for vga_timing_gen

module tb_vga_timing_gen;

  localparam int HA = 8, HFP = 2, HS = 3, HBP = 2;
  localparam int VA = 5, VFP = 1, VS = 2, VBP = 1;
  localparam int HP = 0, VP = 1;
  localparam int CW = 6;
  localparam int HT = HA + HFP + HS + HBP;   // 15
  localparam int VT = VA + VFP + VS + VBP;   // 9
  localparam int FT = HT * VT;               // 135
`ifdef VGA_TIMING_PREFETCH_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int OW = 2 * CW + 5;

  logic          clk = 1'b0;
  logic          clr = 1'b0;
  logic          ce  = 1'b0;
  logic          hsync, vsync, vidon, line_start, frame_start;
  logic [CW-1:0] PixelX, PixelY;
`ifdef VGA_TIMING_PREFETCH_EN
  logic [CW-1:0] NextX, NextY;
  logic          next_vidon;
`endif

  int errors = 0;
  int checks = 0;
  int k = 0;          // ce steps taken since reset
  logic chk_en = 1'b0;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .H_POL(HP), .V_POL(VP), .CW(CW)
  ) dut (
    .clk(clk), .clr(clr), .ce(ce),
    .hsync(hsync), .vsync(vsync), .vidon(vidon),
    .PixelX(PixelX), .PixelY(PixelY),
    .line_start(line_start), .frame_start(frame_start)
`ifdef VGA_TIMING_PREFETCH_EN
    , .NextX(NextX), .NextY(NextY), .next_vidon(next_vidon)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge clr) begin
    if (!clr) k <= 0;
    else if (ce) k <= k + 1;
  end

  // Expected outputs for raster step p, straight from the layout rules
  function automatic logic [OW-1:0] dec(input int p);
    int hc, vc;
    logic vid, hs, vs, ls, fs;
    logic [CW-1:0] x, y;
    hc  = p % HT;
    vc  = (p / HT) % VT;
    vid = (hc < HA) && (vc < VA);
    x   = vid ? CW'(hc) : '0;
    y   = vid ? CW'(vc) : '0;
    hs  = (hc >= HA + HFP && hc < HA + HFP + HS) ? (HP != 0) : (HP == 0);
    vs  = (vc >= VA + VFP && vc < VA + VFP + VS) ? (VP != 0) : (VP == 0);
    ls  = (hc == 0);
    fs  = (hc == 0) && (vc == 0);
    return {hs, vs, vid, x, y, ls, fs};
  endfunction

  function automatic logic [OW-1:0] rst_vec();
    return {(HP == 0), (VP == 0), 1'b0, {CW{1'b0}}, {CW{1'b0}}, 1'b0, 1'b0};
  endfunction

  function automatic logic [OW-1:0] model(input int steps);
    return (steps >= LAT) ? dec(steps - LAT) : rst_vec();
  endfunction

  function automatic logic [OW-1:0] act_vec();
    return {hsync, vsync, vidon, PixelX, PixelY, line_start, frame_start};
  endfunction

  task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (step %0d)", nm, act, exp, k);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (act_vec() !== model(k)) begin
        errors++;
        $display("FAIL outputs: got %h expected %h (step %0d)", act_vec(), model(k), k);
      end
`ifdef VGA_TIMING_PREFETCH_EN
      begin
        logic [OW-1:0] nx;
        nx = (k >= 1) ? dec(k - 1) : rst_vec();
        checks++;
        if ({next_vidon, NextX, NextY} !== {nx[OW-3], nx[2*CW+1:CW+2], nx[CW+1:2]}) begin
          errors++;
          $display("FAIL next: got %h expected %h (step %0d)",
                   {next_vidon, NextX, NextY}, {nx[OW-3], nx[2*CW+1:CW+2], nx[CW+1:2]}, k);
        end
        if (vidon && next_vidon) begin
          checks++;
          if (NextX !== PixelX + 1'b1) begin
            errors++;
            $display("FAIL next_lead: got %0d expected %0d", NextX, PixelX + 1'b1);
          end
        end
      end
`endif
    end
  end

  // Advance until the outputs show raster step p (ce held high)
  task automatic go_to(input int p);
    int n;
    n = 0;
    while (k < p + LAT && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (k != p + LAT) begin
      errors++;
      $display("FAIL goto: got step %0d expected %0d", k, p + LAT);
    end
  endtask

  initial begin
    int base;
    // Reset held while clocks run
    repeat (2) @(posedge clk);
    chk_en = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #2 ce = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    lit("reset_vec", 32'(act_vec()), 32'(rst_vec()));
    lit("reset_hsync", 32'(hsync), 32'd1);
    lit("reset_vsync", 32'(vsync), 32'd0);

    // Release and scan one full frame with ce=1
    @(posedge clk);
    #2 clr = 1'b1; ce = 1'b1;
    go_to(0);
    lit("first_vidon", 32'(vidon), 32'd1);
    lit("first_xy", {PixelX, PixelY}, 32'd0);
    lit("first_ls", 32'(line_start), 32'd1);
    lit("first_fs", 32'(frame_start), 32'd1);
    go_to(9);   lit("hs_before", 32'(hsync), 32'd1);
    go_to(10);  lit("hs_start", 32'(hsync), 32'd0);
    go_to(12);  lit("hs_last", 32'(hsync), 32'd0);
    go_to(13);  lit("hs_end", 32'(hsync), 32'd1);
    go_to(15);  lit("line2_ls", {line_start, frame_start, vidon}, 32'b101);
    lit("line2_y", 32'(PixelY), 32'd1);
    go_to(67);  lit("last_px", {vidon, PixelX, PixelY}, {1'b1, 6'd7, 6'd4});
    go_to(68);  lit("after_px", {vidon, PixelX, PixelY}, 32'd0);
    go_to(75);  lit("blank_line", {vidon, PixelY, line_start}, 32'b1);
    go_to(89);  lit("vs_before", 32'(vsync), 32'd0);
    go_to(90);  lit("vs_start", 32'(vsync), 32'd1);
    go_to(104); lit("vs_mid", 32'(vsync), 32'd1);
    go_to(120); lit("vs_end", 32'(vsync), 32'd0);
    go_to(134); lit("pre_wrap", {frame_start, vidon}, 32'd0);
    go_to(135); lit("wrap", {frame_start, line_start, vidon, PixelX, PixelY}, {3'b111, 12'd0});

    // ce on every 3rd clock for two frames
    for (int i = 0; i < 3 * 2 * FT; i++) begin
      @(posedge clk);
      #2 ce = (i % 3 == 0);
    end

    // Random ce
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #2 ce = 1'($urandom_range(0, 1));
    end

    // Asynchronous reset mid-frame at (5,3)
    @(posedge clk);
    #2 ce = 1'b1;
    base = ((k / FT) + 1) * FT + 50;
    go_to(base);
    lit("mid_active", {vidon, PixelX, PixelY}, {1'b1, 6'd5, 6'd3});
    #1 clr = 1'b0;
    #1 lit("async_rst", 32'(act_vec()), 32'(rst_vec()));
    repeat (2) @(posedge clk);
    #2 clr = 1'b1;
    go_to(0);
    lit("restart", {frame_start, line_start, vidon, PixelX, PixelY}, {3'b111, 12'd0});

    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #2 ce = 1'($urandom_range(0, 3) != 0);
    end
    @(negedge clk);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
